reg_bank_write: RTL and testbench
=================================

# reg_bank_write

Write side of the 16 x 32-bit CPU register bank: it holds r0..r15 and drives them straight into the 16:1 read mux. It accepts single-register writes from write-back. It also runs a block-write sequencer for load-multiple instructions, writing a burst of data words into the registers selected by a 16-bit mask, lowest index first, one word per accepted handshake.

## Interface
- DATA_W, 32, register width
- R15_RST, 32'h0000_0000, reset value of r15 (program counter)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  single-register write strobe
- wr_sel  in  4  single-write target index
- wr_data  in  DATA_W  single-write data
- blk_start  in  1  start a block write; sampled only in IDLE
- blk_mask  in  16  register list; bit n selects rn; sampled with blk_start
- blk_valid  in  1  blk_data holds a valid word
- blk_data  in  DATA_W  burst data word
- blk_ready  out  1  sequencer accepts a word this cycle
- blk_busy  out  1  sequencer not IDLE
- blk_done  out  1  one-cycle pulse when a block write completes
- r0..r15  out  DATA_W each  registered contents, fed to the read mux
- pc_inc  in  1  present only with REG_BANK_PC_INC_EN

## Operation
- States:
  - IDLE: blk_start=1 loads the remaining mask `rem` <= blk_mask.
    - blk_mask != 0 -> BURST.
    - blk_mask == 0 -> DONE.
  - BURST:
    - idx = lowest set bit of `rem`; blk_ready=1.
    - On blk_valid & blk_ready: r[idx] <= blk_data and clear bit idx in `rem`.
    - If that clears the last bit -> DONE; otherwise stay in BURST.
    - blk_valid=0 stalls the sequence indefinitely with no state change.
  - DONE: blk_done=1 for exactly one cycle -> IDLE.
- blk_busy=1 in BURST and DONE. blk_ready=1 only in BURST and is a pure function of state.
- blk_start outside IDLE is ignored. A new blk_start may be accepted in the cycle after DONE.
- Single writes (wr_en=1): r[wr_sel] <= wr_data in any state.
- If a single write and a burst write hit the same register in the same cycle, the burst word wins and the single write is dropped. Writes to different registers both complete.
- Write data is stored unmodified; no sign extension, no width conversion.

## Timing
- All register writes take effect at the rising edge; the new value is visible on rN in the following cycle. There is no write-through bypass.
- Burst throughput is 1 word per cycle while blk_valid is held high.
- Burst latency: popcount(mask) accepted words, then one DONE cycle.
- blk_mask=0: IDLE -> DONE -> IDLE, with blk_done high 1 cycle after start.
- Reset values:
  - r0..r14 = 0; r15 = R15_RST.
  - State IDLE, rem = 0.
  - blk_ready = 0, blk_busy = 0, blk_done = 0.
- Reset asserted mid-burst aborts the burst:
  - Registers already written are overwritten by their reset values.
  - No blk_done pulse is produced.

## Configuration
- REG_BANK_PC_INC_EN defined:
  - Port pc_inc exists.
  - In any cycle where pc_inc=1 and r15 is not written by a single or burst write, r15 <= r15 + 4, wrapping modulo 2^DATA_W.
  - Any write to r15 in that cycle takes priority over the increment.
- REG_BANK_PC_INC_EN undefined:
  - Port pc_inc is absent.
  - r15 changes only on writes and reset.

## Test plan
- Reset, then wr_en=1, wr_sel=4'h3, wr_data=32'hDEAD_BEEF -> next cycle r3=32'hDEAD_BEEF; all other registers 0; r15=R15_RST.
- blk_start with blk_mask=16'h8011, blk_valid held 1, data 32'h11,32'h22,32'h33 -> r0=11h, r4=22h, r15=33h on 3 consecutive ready cycles; blk_done pulses one cycle after the 3rd accept.
- Same burst with blk_valid low for 2 cycles after the first word -> r4 is not written until valid returns; blk_ready stays 1; done is delayed by 2 cycles.
- BURST with idx=5 while wr_en=1 and wr_sel=5 -> r5 holds blk_data. Repeat with wr_sel=6 -> r5=blk_data and r6=wr_data.
- blk_mask=16'h0000 -> blk_done high in the cycle after start; no register changes. rst asserted after 1 of 3 burst words -> all outputs return to reset values and no blk_done pulse.
- With REG_BANK_PC_INC_EN, R15_RST=0, pc_inc=1 for 3 cycles -> r15=12; then wr_sel=15, wr_data=100h with pc_inc=1 -> r15=100h (no +4); with R15_RST=32'hFFFF_FFFC and one pc_inc -> r15=0.

Source files
------------

// File: rtl/reg_bank_write.sv
// Write side of the 16 x DATA_W register bank: single writes plus a masked block-write sequencer.
// Optional feature macro REG_BANK_PC_INC_EN adds pc_inc_i, which auto-increments r15 by 4.
module reg_bank_write #(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] R15_RST = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [3:0]        wr_sel_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              blk_start_i,
   input  logic [15:0]       blk_mask_i,
   input  logic              blk_valid_i,
   input  logic [DATA_W-1:0] blk_data_i,
`ifdef REG_BANK_PC_INC_EN
   input  logic              pc_inc_i,
`endif
   output logic              blk_ready_o,
   output logic              blk_busy_o,
   output logic              blk_done_o,
   output logic [DATA_W-1:0] r0_o,
   output logic [DATA_W-1:0] r1_o,
   output logic [DATA_W-1:0] r2_o,
   output logic [DATA_W-1:0] r3_o,
   output logic [DATA_W-1:0] r4_o,
   output logic [DATA_W-1:0] r5_o,
   output logic [DATA_W-1:0] r6_o,
   output logic [DATA_W-1:0] r7_o,
   output logic [DATA_W-1:0] r8_o,
   output logic [DATA_W-1:0] r9_o,
   output logic [DATA_W-1:0] r10_o,
   output logic [DATA_W-1:0] r11_o,
   output logic [DATA_W-1:0] r12_o,
   output logic [DATA_W-1:0] r13_o,
   output logic [DATA_W-1:0] r14_o,
   output logic [DATA_W-1:0] r15_o
);

   typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

   state_t            state_q, state_d;
   logic [15:0]       rem_q, rem_d;
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic [3:0]        idx;
   logic              accept;

   // Target of the current burst word: lowest register still pending.
   always_comb begin
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rem_q[i]) idx = 4'(i);
      end
   end

   assign accept = (state_q == BURST) && blk_valid_i;

   // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      blk_ready_o = 1'b0;
      blk_busy_o  = 1'b0;
      blk_done_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (blk_start_i) begin
               rem_d   = blk_mask_i;
               state_d = (blk_mask_i != 16'd0) ? BURST : DONE;
            end
         end
         BURST: begin
            blk_ready_o = 1'b1;
            blk_busy_o  = 1'b1;
            if (blk_valid_i) begin
               rem_d   = rem_q & (rem_q - 16'd1);
               state_d = (rem_d == 16'd0) ? DONE : BURST;
            end
         end
         DONE: begin
            blk_busy_o = 1'b1;
            blk_done_o = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The burst write is applied last so it overrides a single write to the same register.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_i) regs_d[wr_sel_i] = wr_data_i;
      if (accept)  regs_d[idx]      = blk_data_i;
`ifdef REG_BANK_PC_INC_EN
      if (pc_inc_i && !(wr_en_i && wr_sel_i == 4'hF) && !(accept && idx == 4'hF))
         regs_d[15] = regs_q[15] + DATA_W'(4);
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rem_q   <= 16'd0;
         // NOTE: the bank is a register file, not RAM, so every entry has a defined reset value.
         for (int i = 0; i < 15; i++) regs_q[i] <= '0;
         regs_q[15] <= R15_RST;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         regs_q  <= regs_d;
      end
   end

   assign r0_o  = regs_q[0];
   assign r1_o  = regs_q[1];
   assign r2_o  = regs_q[2];
   assign r3_o  = regs_q[3];
   assign r4_o  = regs_q[4];
   assign r5_o  = regs_q[5];
   assign r6_o  = regs_q[6];
   assign r7_o  = regs_q[7];
   assign r8_o  = regs_q[8];
   assign r9_o  = regs_q[9];
   assign r10_o = regs_q[10];
   assign r11_o = regs_q[11];
   assign r12_o = regs_q[12];
   assign r13_o = regs_q[13];
   assign r14_o = regs_q[14];
   assign r15_o = regs_q[15];

endmodule

// File: tb/tb_reg_bank_write.sv
// Bench for reg_bank_write: directed scenarios plus random traffic against a queue-based model.
// Define REG_BANK_PC_INC_EN to also exercise the r15 auto-increment.
module tb_reg_bank_write;

`ifdef REG_BANK_PC_INC_EN
   localparam logic [31:0] R15_RST = 32'h0000_0000;
`else
   localparam logic [31:0] R15_RST = 32'h0000_1000;
`endif

   logic        clk = 1'b0;
   logic        rst, wr_en, blk_start, blk_valid, pc_inc;
   logic [3:0]  wr_sel;
   logic [31:0] wr_data, blk_data;
   logic [15:0] blk_mask;
   logic        blk_ready, blk_busy, blk_done;
   logic [31:0] r_o [16];

   int n_checks = 0;
   int n_pass   = 0;

   // Model: register contents, phase (0 idle, 1 burst, 2 done) and the pending register list.
   logic [31:0] m_r [16];
   int          m_phase = 0;
   int          m_q [$];

   always #5 clk = ~clk;

   reg_bank_write #(.DATA_W(32), .R15_RST(R15_RST)) dut (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
      .blk_start_i(blk_start), .blk_mask_i(blk_mask), .blk_valid_i(blk_valid), .blk_data_i(blk_data),
`ifdef REG_BANK_PC_INC_EN
      .pc_inc_i(pc_inc),
`endif
      .blk_ready_o(blk_ready), .blk_busy_o(blk_busy), .blk_done_o(blk_done),
      .r0_o(r_o[0]), .r1_o(r_o[1]), .r2_o(r_o[2]), .r3_o(r_o[3]),
      .r4_o(r_o[4]), .r5_o(r_o[5]), .r6_o(r_o[6]), .r7_o(r_o[7]),
      .r8_o(r_o[8]), .r9_o(r_o[9]), .r10_o(r_o[10]), .r11_o(r_o[11]),
      .r12_o(r_o[12]), .r13_o(r_o[13]), .r14_o(r_o[14]), .r15_o(r_o[15])
   );

`ifdef REG_BANK_PC_INC_EN
   logic        w_ready, w_busy, w_done;
   logic [31:0] w_r [16];
   reg_bank_write #(.DATA_W(32), .R15_RST(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
      .blk_start_i(blk_start), .blk_mask_i(blk_mask), .blk_valid_i(blk_valid), .blk_data_i(blk_data),
      .pc_inc_i(pc_inc),
      .blk_ready_o(w_ready), .blk_busy_o(w_busy), .blk_done_o(w_done),
      .r0_o(w_r[0]), .r1_o(w_r[1]), .r2_o(w_r[2]), .r3_o(w_r[3]),
      .r4_o(w_r[4]), .r5_o(w_r[5]), .r6_o(w_r[6]), .r7_o(w_r[7]),
      .r8_o(w_r[8]), .r9_o(w_r[9]), .r10_o(w_r[10]), .r11_o(w_r[11]),
      .r12_o(w_r[12]), .r13_o(w_r[13]), .r14_o(w_r[14]), .r15_o(w_r[15])
   );
`endif

   // Advance one clock: predict the model from current inputs, then land on the next falling edge.
   task automatic tick();
      logic [31:0] nx [16];
      int  ph;
      bit  acc, w15;
      nx = m_r;
      ph = m_phase;
      if (rst) begin
         for (int i = 0; i < 16; i++) nx[i] = 32'd0;
         nx[15] = R15_RST;
         m_q.delete();
         ph = 0;
      end else begin
         acc = (m_phase == 1) && blk_valid;
         w15 = 1'b0;
         if (wr_en) begin
            nx[wr_sel] = wr_data;
            w15 = (wr_sel == 4'hF);
         end
         if (acc) begin
            nx[m_q[0]] = blk_data;
            if (m_q[0] == 15) w15 = 1'b1;
         end
`ifdef REG_BANK_PC_INC_EN
         if (pc_inc && !w15) nx[15] = m_r[15] + 32'd4;
`endif
         case (m_phase)
            0: if (blk_start) begin
                  for (int i = 0; i < 16; i++) if (blk_mask[i]) m_q.push_back(i);
                  ph = (m_q.size() == 0) ? 2 : 1;
               end
            1: if (acc) begin
                  m_q.delete(0);
                  if (m_q.size() == 0) ph = 2;
               end
            default: ph = 0;
         endcase
      end
      @(posedge clk);
      m_r     = nx;
      m_phase = ph;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; wr_en = 1'b0; wr_sel = 4'd0; wr_data = 32'd0;
      blk_start = 1'b0; blk_mask = 16'd0; blk_valid = 1'b0; blk_data = 32'd0; pc_inc = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (r_o[i] !== ((i == 15) ? R15_RST : 32'd0))
            $display("FAIL reset_r%0d: got %h want %h", i, r_o[i], (i == 15) ? R15_RST : 32'd0);
         else n_pass++;
      end
      n_checks++;
      if ({blk_ready, blk_busy, blk_done} !== 3'b000)
         $display("FAIL reset_flags: got %b want 000", {blk_ready, blk_busy, blk_done});
      else n_pass++;
   endtask

   task automatic test_single();
      wr_en = 1'b1; wr_sel = 4'h3; wr_data = 32'hDEAD_BEEF;
      tick();
      wr_en = 1'b0;
      n_checks++;
      if (r_o[3] !== 32'hDEAD_BEEF) $display("FAIL single_r3: got %h want deadbeef", r_o[3]);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (r_o[i] !== m_r[i]) $display("FAIL single_r%0d: got %h want %h", i, r_o[i], m_r[i]);
         else n_pass++;
      end
   endtask

   task automatic test_burst();
      blk_start = 1'b1; blk_mask = 16'h8011; blk_valid = 1'b1; blk_data = 32'h11;
      tick();
      blk_start = 1'b0;
      n_checks++;
      if (blk_ready !== 1'b1) $display("FAIL burst_ready: got %b want 1", blk_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (r_o[0] !== 32'h11) $display("FAIL burst_r0: got %h want 11", r_o[0]);
      else n_pass++;
      blk_data = 32'h22;
      tick();
      n_checks++;
      if (r_o[4] !== 32'h22 || blk_done !== 1'b0)
         $display("FAIL burst_r4: got %h done %b want 22 done 0", r_o[4], blk_done);
      else n_pass++;
      blk_data = 32'h33;
      tick();
      blk_valid = 1'b0;
      n_checks++;
      if (r_o[15] !== 32'h33 || blk_done !== 1'b1 || blk_ready !== 1'b0)
         $display("FAIL burst_r15_done: got %h done %b ready %b want 33 1 0", r_o[15], blk_done, blk_ready);
      else n_pass++;
      tick();
      n_checks++;
      if ({blk_ready, blk_busy, blk_done} !== 3'b000)
         $display("FAIL burst_end_flags: got %b want 000", {blk_ready, blk_busy, blk_done});
      else n_pass++;
   endtask

   task automatic test_stall();
      int cycles;
      do_reset();
      blk_start = 1'b1; blk_mask = 16'h8011;
      tick();
      blk_start = 1'b0; blk_valid = 1'b1; blk_data = 32'h11;
      tick();
      blk_valid = 1'b0; blk_data = 32'h22;
      for (int s = 0; s < 2; s++) begin
         tick();
         n_checks++;
         if (blk_ready !== 1'b1 || r_o[4] !== 32'd0 || blk_done !== 1'b0)
            $display("FAIL stall_%0d: ready %b r4 %h done %b want 1 0 0", s, blk_ready, r_o[4], blk_done);
         else n_pass++;
      end
      blk_valid = 1'b1;
      cycles = 0;
      while (blk_done !== 1'b1 && cycles < 10) begin
         if (cycles == 1) blk_data = 32'h33;
         tick();
         cycles++;
      end
      blk_valid = 1'b0;
      n_checks++;
      if (cycles != 2 || r_o[4] !== 32'h22 || r_o[15] !== 32'h33)
         $display("FAIL stall_resume: cycles %0d r4 %h r15 %h want 2 22 33", cycles, r_o[4], r_o[15]);
      else n_pass++;
      tick();
   endtask

   task automatic test_collision();
      blk_start = 1'b1; blk_mask = 16'h0020;
      tick();
      blk_start = 1'b0; blk_valid = 1'b1; blk_data = 32'hAAAA_5555;
      wr_en = 1'b1; wr_sel = 4'h5; wr_data = 32'h0000_1234;
      tick();
      wr_en = 1'b0; blk_valid = 1'b0;
      n_checks++;
      if (r_o[5] !== 32'hAAAA_5555) $display("FAIL collide_same: got %h want aaaa5555", r_o[5]);
      else n_pass++;
      tick();
      blk_start = 1'b1; blk_mask = 16'h0020;
      tick();
      blk_start = 1'b0; blk_valid = 1'b1; blk_data = 32'h5A5A_0001;
      wr_en = 1'b1; wr_sel = 4'h6; wr_data = 32'h0000_6666;
      tick();
      wr_en = 1'b0; blk_valid = 1'b0;
      n_checks++;
      if (r_o[5] !== 32'h5A5A_0001 || r_o[6] !== 32'h0000_6666)
         $display("FAIL collide_diff: r5 %h r6 %h want 5a5a0001 00006666", r_o[5], r_o[6]);
      else n_pass++;
      tick();
   endtask

   task automatic test_empty_mask();
      logic [31:0] snap [16];
      snap = m_r;
      blk_start = 1'b1; blk_mask = 16'h0000;
      tick();
      blk_start = 1'b0;
      n_checks++;
      if (blk_done !== 1'b1 || blk_busy !== 1'b1 || blk_ready !== 1'b0)
         $display("FAIL empty_done: done %b busy %b ready %b want 1 1 0", blk_done, blk_busy, blk_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (blk_done !== 1'b0 || blk_busy !== 1'b0)
         $display("FAIL empty_idle: done %b busy %b want 0 0", blk_done, blk_busy);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (r_o[i] !== snap[i]) $display("FAIL empty_r%0d: got %h want %h", i, r_o[i], snap[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_abort();
      blk_start = 1'b1; blk_mask = 16'h0E00;
      tick();
      blk_start = 1'b0; blk_valid = 1'b1; blk_data = 32'h0000_F00D;
      tick();
      n_checks++;
      if (r_o[9] !== 32'h0000_F00D) $display("FAIL abort_r9: got %h want 0000f00d", r_o[9]);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0; blk_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if ({blk_ready, blk_busy, blk_done} !== 3'b000)
            $display("FAIL abort_flags_%0d: got %b want 000", c, {blk_ready, blk_busy, blk_done});
         else n_pass++;
         tick();
      end
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (r_o[i] !== ((i == 15) ? R15_RST : 32'd0))
            $display("FAIL abort_r%0d: got %h want %h", i, r_o[i], (i == 15) ? R15_RST : 32'd0);
         else n_pass++;
      end
   endtask

`ifdef REG_BANK_PC_INC_EN
   task automatic test_pc_inc();
      do_reset();
      pc_inc = 1'b1;
      tick();
      n_checks++;
      if (w_r[15] !== 32'd0) $display("FAIL pc_wrap: got %h want 00000000", w_r[15]);
      else n_pass++;
      tick();
      tick();
      n_checks++;
      if (r_o[15] !== 32'd12) $display("FAIL pc_inc3: got %h want 0000000c", r_o[15]);
      else n_pass++;
      wr_en = 1'b1; wr_sel = 4'hF; wr_data = 32'h100;
      tick();
      wr_en = 1'b0; pc_inc = 1'b0;
      n_checks++;
      if (r_o[15] !== 32'h100) $display("FAIL pc_write_prio: got %h want 00000100", r_o[15]);
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 149) == 0);
         wr_en     = $urandom_range(0, 1) == 1;
         wr_sel    = 4'($urandom_range(0, 15));
         wr_data   = $urandom;
         blk_start = ($urandom_range(0, 5) == 0);
         blk_mask  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
         blk_valid = ($urandom_range(0, 3) != 0);
         blk_data  = $urandom;
         pc_inc    = $urandom_range(0, 1) == 1;
         tick();
         n_checks++;
         if (blk_ready !== (m_phase == 1) || blk_busy !== (m_phase != 0) || blk_done !== (m_phase == 2))
            $display("FAIL random_flags cyc %0d: got %b%b%b phase %0d", c, blk_ready, blk_busy, blk_done, m_phase);
         else n_pass++;
         for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (r_o[i] !== m_r[i]) $display("FAIL random_r%0d cyc %0d: got %h want %h", i, c, r_o[i], m_r[i]);
            else n_pass++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_burst();
      test_stall();
      test_collision();
      test_empty_mask();
      test_reset_abort();
`ifdef REG_BANK_PC_INC_EN
      test_pc_inc();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
